// File: rtl/trig_pkg.sv
// Shared definitions for the channel readout sequencer: sizes, FSM state
// encoding and header word field offsets.
package trig_pkg;

  localparam int NUM_CHAN     = 5;
  localparam int TRIG_NUM_W   = 24;
  localparam int HDR_W        = 32;
  localparam int HDR_TRIG_LSB = 0;
  localparam int HDR_MASK_LSB = 24;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    SELECT,
    REQUEST,
    WAIT_DONE,
    FINISH
  } rd_state_t;

endpackage

// File: rtl/chan_readout_sequencer_prio_select.sv
// Lowest-set-bit finder: returns the winning bit as one-hot, its index,
// and an empty flag when no bit is set.
module prio_select #(
  parameter int N = 5,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         empty
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    empty  = (vec == '0);
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = W'(i);
      end
    end
  end

endmodule

// File: rtl/chan_readout_sequencer.sv
// Trigger-number FIFO consumer: emits a header per fill, then reads out each
// enabled channel lowest-first. Optional per-channel timeout: READOUT_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | fifo_ready high, waiting for a trigger number
// HEADER    | header word offered to the event builder
// SELECT    | pick next enabled channel, or finish if none remain
// REQUEST   | chan_req held on the selected channel until ack
// WAIT_DONE | request accepted, waiting for that channel's done
// FINISH    | one-cycle chan_readout_done pulse
module chan_readout_sequencer #(
  parameter int NUM_CHAN       = trig_pkg::NUM_CHAN,
  parameter int TRIG_NUM_W     = trig_pkg::TRIG_NUM_W,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fifo_valid,
  output logic                        fifo_ready,
  input  logic [TRIG_NUM_W-1:0]       trig_num,
  input  logic [NUM_CHAN-1:0]         chan_en,
  output logic [NUM_CHAN-1:0]         chan_req,
  input  logic [NUM_CHAN-1:0]         chan_ack,
  input  logic [NUM_CHAN-1:0]         chan_done,
  output logic                        hdr_valid,
  input  logic                        hdr_ready,
  output logic [trig_pkg::HDR_W-1:0]  hdr_data,
  output logic                        chan_readout_done,
  output logic                        busy,
  output logic [NUM_CHAN-1:0]         timeout_flags
);
  import trig_pkg::*;

  localparam int IDX_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

  rd_state_t           state, state_next;
  logic [NUM_CHAN-1:0] rem_q, rem_next;
  logic [IDX_W-1:0]    idx_q, idx_next;
  logic [NUM_CHAN-1:0] sel_cur, sel_next;
  logic [NUM_CHAN-1:0] pick_onehot;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_empty;
  logic [HDR_W-1:0]    hdr_next;
  logic                pop, ack_hit, done_hit, timeout_hit;

  prio_select #(.N(NUM_CHAN), .W(IDX_W)) u_prio (
    .vec    (rem_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .empty  (pick_empty)
  );

  assign pop      = (state == IDLE) && fifo_valid && fifo_ready;
  assign sel_cur  = NUM_CHAN'(1) << idx_q;
  assign sel_next = NUM_CHAN'(1) << idx_next;
  // Only the selected channel's handshake bits matter; others are masked off.
  assign ack_hit  = |(chan_ack & sel_cur);
  assign done_hit = |(chan_done & sel_cur);

  always_comb begin
    hdr_next = '0;
    hdr_next[HDR_TRIG_LSB +: TRIG_NUM_W] = trig_num;
    hdr_next[HDR_MASK_LSB +: NUM_CHAN]   = chan_en;
  end

  always_comb begin
    state_next = state;
    rem_next   = rem_q;
    idx_next   = idx_q;
    case (state)
      IDLE: begin
        if (pop) begin
          rem_next   = chan_en;
          state_next = HEADER;
        end
      end
      HEADER: begin
        if (hdr_valid && hdr_ready) state_next = SELECT;
      end
      SELECT: begin
        if (pick_empty) begin
          state_next = FINISH;
        end else begin
          rem_next   = rem_q & ~pick_onehot;
          idx_next   = pick_idx;
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        if (ack_hit)          state_next = done_hit ? SELECT : WAIT_DONE;
        else if (timeout_hit) state_next = SELECT;
      end
      WAIT_DONE: begin
        if (done_hit || timeout_hit) state_next = SELECT;
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      rem_q             <= '0;
      idx_q             <= '0;
      hdr_data          <= '0;
      fifo_ready        <= 1'b0;
      busy              <= 1'b0;
      hdr_valid         <= 1'b0;
      chan_req          <= '0;
      chan_readout_done <= 1'b0;
    end else begin
      state             <= state_next;
      rem_q             <= rem_next;
      idx_q             <= idx_next;
      if (pop) hdr_data <= hdr_next;
      fifo_ready        <= (state_next == IDLE);
      busy              <= (state_next != IDLE);
      hdr_valid         <= (state_next == HEADER);
      chan_req          <= (state_next == REQUEST) ? sel_next : '0;
      chan_readout_done <= (state_next == FINISH);
    end
  end

`ifdef READOUT_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  logic [9:0]          timer_q;
  logic [NUM_CHAN-1:0] flags_q;
  logic                waiting;

  assign waiting       = (state == REQUEST) || (state == WAIT_DONE);
  assign timeout_hit   = waiting && (timer_q == TO_LAST);
  assign timeout_flags = flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    timer_q <= '0;
    else if (state_next != state) timer_q <= '0;
    else if (waiting)             timer_q <= timer_q + 10'd1;
  end

  // A handshake landing on the timeout cycle wins; no flag in that case.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (pop) begin
      flags_q <= '0;
    end else if (timeout_hit && ((state == REQUEST && !ack_hit) ||
                                 (state == WAIT_DONE && !done_hit))) begin
      flags_q <= flags_q | sel_cur;
    end
  end
`else
  logic [31:0] unused_timeout_cfg;

  assign unused_timeout_cfg = TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
  assign timeout_flags      = '0;
`endif

endmodule

// File: tb/tb_chan_readout_sequencer.sv
// Directed bench for chan_readout_sequencer: table-driven fills plus
// backpressure, reset-mid-fill and (with READOUT_TIMEOUT_EN) timeout sequences.
module tb_chan_readout_sequencer;

  logic        clk, reset;
  logic        fifo_valid, fifo_ready;
  logic [23:0] trig_num;
  logic [4:0]  chan_en, chan_req, chan_ack, chan_done, timeout_flags;
  logic        hdr_valid, hdr_ready;
  logic [31:0] hdr_data;
  logic        chan_readout_done, busy;

  int n_cmp = 0;
  int n_err = 0;

  int         ack_dly = 0;
  int         done_dly = 0;
  logic [4:0] hang = '0;
  logic       noise = 1'b0;

  int         ph, rcnt;
  logic [4:0] cur, resp_av, resp_dv;

  typedef struct {
    logic [23:0] trig;
    logic [4:0]  en;
    int          a;
    int          d;
    logic        noise;
    logic [31:0] hdr;
    logic [24:0] seq;
    int          n;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  chan_readout_sequencer #(.NUM_CHAN(5), .TRIG_NUM_W(24), .TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_valid        (fifo_valid),
    .fifo_ready        (fifo_ready),
    .trig_num          (trig_num),
    .chan_en           (chan_en),
    .chan_req          (chan_req),
    .chan_ack          (chan_ack),
    .chan_done         (chan_done),
    .hdr_valid         (hdr_valid),
    .hdr_ready         (hdr_ready),
    .hdr_data          (hdr_data),
    .chan_readout_done (chan_readout_done),
    .busy              (busy),
    .timeout_flags     (timeout_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Channel model: acks after ack_dly cycles of request, done done_dly cycles
  // after ack; optional random handshake bits on unselected channels.
  initial begin
    chan_ack = '0;
    chan_done = '0;
    ph = 0;
    rcnt = 0;
    cur = '0;
    forever begin
      @(posedge clk);
      #2;
      resp_av = '0;
      resp_dv = '0;
      if (ph == 2 && chan_req != '0) ph = 0;
      if (ph == 0 && chan_req != '0) begin
        cur = chan_req;
        rcnt = 0;
        ph = 1;
      end
      if (ph == 1) begin
        if (rcnt == ack_dly) begin
          resp_av = cur;
          rcnt = 0;
          ph = 2;
          if (done_dly == 0) begin
            if ((cur & hang) == '0) resp_dv = cur;
            ph = 0;
          end
        end else begin
          rcnt++;
        end
      end else if (ph == 2) begin
        rcnt++;
        if (rcnt == done_dly) begin
          if ((cur & hang) == '0) resp_dv = cur;
          ph = 0;
        end
      end
      if (noise) begin
        resp_av = resp_av | (5'($urandom) & ~cur);
        resp_dv = resp_dv | (5'($urandom) & ~cur);
      end
      chan_ack = resp_av;
      chan_done = resp_dv;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_fill(input vec_t v, input logic [4:0] hng, input logic [4:0] exp_flags,
                          input string tag);
    bit          got, onehot_ok, hdr_seen, hdr_stable;
    logic [24:0] seq;
    logic [4:0]  prev;
    logic [31:0] hdr_first;
    int          nreq, lat;
    ack_dly = v.a;
    done_dly = v.d;
    noise = v.noise;
    hang = hng;
    fifo_valid = 1'b1;
    trig_num = v.trig;
    chan_en = v.en;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (fifo_ready) got = 1'b1;
      step();
    end
    check({tag, "_pop"}, 64'(got), 64'd1);
    fifo_valid = 1'b0;
    trig_num = 24'h5A5A5A;
    chan_en = ~v.en;
    seq = '0;
    nreq = 0;
    prev = '0;
    onehot_ok = 1'b1;
    hdr_seen = 1'b0;
    hdr_stable = 1'b1;
    hdr_first = 'x;
    lat = 0;
    for (int j = 0; j < 200; j++) begin
      if (hdr_valid) begin
        if (!hdr_seen) begin
          hdr_first = hdr_data;
          hdr_seen = 1'b1;
        end else if (hdr_data !== hdr_first) begin
          hdr_stable = 1'b0;
        end
      end
      if (chan_req != '0 && chan_req !== prev) begin
        if (nreq < 5) seq[nreq*5 +: 5] = chan_req;
        nreq++;
      end
      if ((chan_req & (chan_req - 5'd1)) != '0) onehot_ok = 1'b0;
      prev = chan_req;
      if (chan_readout_done) begin
        lat = j + 1;
        break;
      end
      step();
    end
    check({tag, "_hdr"}, 64'(hdr_first), 64'(v.hdr));
    check({tag, "_req_seq"}, 64'(seq), 64'(v.seq));
    check({tag, "_req_count"}, 64'(nreq), 64'(v.n));
    check({tag, "_onehot_hdrstable"}, 64'({onehot_ok, hdr_stable}), 64'(2'b11));
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_flags"}, 64'(timeout_flags), 64'(exp_flags));
    step();
    check({tag, "_after_done"}, 64'({chan_readout_done, fifo_ready, busy}), 64'(3'b010));
  endtask

  initial begin : main
    bit   got, done_seen, seen_req, in_wait, bad;
    int   pops;
    vec_t vr;
`ifdef READOUT_TIMEOUT_EN
    vec_t vt;
`endif
    vecs[0] = '{24'h00002A, 5'b11111, 1, 3, 1'b0, 32'h1F00002A,
                {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001}, 5, 33};
    vecs[1] = '{24'h123456, 5'b10100, 1, 3, 1'b1, 32'h14123456,
                {15'b0, 5'b10000, 5'b00100}, 2, 15};
    vecs[2] = '{24'hABCDEF, 5'b00000, 0, 0, 1'b1, 32'h00ABCDEF, 25'b0, 0, 3};
    vecs[3] = '{24'hFFFFFF, 5'b01000, 0, 0, 1'b0, 32'h08FFFFFF, {20'b0, 5'b01000}, 1, 5};
    vecs[4] = '{24'h000001, 5'b10001, 0, 2, 1'b1, 32'h11000001,
                {15'b0, 5'b10000, 5'b00001}, 2, 11};
    vecs[5] = '{24'h800000, 5'b00110, 2, 0, 1'b0, 32'h06800000,
                {15'b0, 5'b00100, 5'b00010}, 2, 11};

    reset = 1'b1;
    fifo_valid = 1'b0;
    trig_num = '0;
    chan_en = '0;
    hdr_ready = 1'b1;
    step();
    step();
    check("reset_outputs", {fifo_ready, busy, hdr_valid, chan_readout_done, chan_req,
                            timeout_flags, hdr_data}, 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) run_fill(vecs[i], 5'b0, 5'b0, $sformatf("vec%0d", i));

    // Header backpressure with fifo_valid held high throughout.
    ack_dly = 0;
    done_dly = 0;
    noise = 1'b0;
    hang = '0;
    hdr_ready = 1'b0;
    fifo_valid = 1'b1;
    trig_num = 24'h0055AA;
    chan_en = 5'b00001;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (fifo_ready) got = 1'b1;
      step();
    end
    check("bp_pop", 64'(got), 64'd1);
    pops = 1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!(hdr_valid && hdr_data == 32'h010055AA && chan_req == '0 && !fifo_ready)) bad = 1'b1;
      if (fifo_ready) pops++;
      step();
    end
    check("bp_hold", 64'(bad), 64'd0);
    hdr_ready = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 50 && !done_seen; k++) begin
      if (fifo_ready) pops++;
      if (chan_readout_done) begin
        fifo_valid = 1'b0;
        done_seen = 1'b1;
      end else begin
        step();
      end
    end
    fifo_valid = 1'b0;
    check("bp_done", 64'(done_seen), 64'd1);
    check("bp_single_pop", 64'(pops), 64'd1);
    step();

    // Reset while waiting for done on channel 2.
    ack_dly = 0;
    done_dly = 1;
    hang = 5'b00100;
    fifo_valid = 1'b1;
    trig_num = 24'h0A0B0C;
    chan_en = 5'b00100;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (fifo_ready) got = 1'b1;
      step();
    end
    fifo_valid = 1'b0;
    seen_req = 1'b0;
    in_wait = 1'b0;
    for (int k = 0; k < 50 && !in_wait; k++) begin
      if (chan_req == 5'b00100) seen_req = 1'b1;
      else if (seen_req && chan_req == '0) in_wait = 1'b1;
      if (!in_wait) step();
    end
    check("rst_reach_wait", 64'(in_wait), 64'd1);
    repeat (3) step();
    check("rst_busy_before", 64'(busy), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    check("rst_async_zero", {fifo_ready, busy, hdr_valid, chan_readout_done, chan_req,
                             timeout_flags, hdr_data}, 64'd0);
    step();
    reset = 1'b0;
    hang = '0;
    vr = '{24'h000100, 5'b11111, 1, 3, 1'b0, 32'h1F000100,
           {5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001}, 5, 33};
    run_fill(vr, 5'b0, 5'b0, "post_rst");

`ifdef READOUT_TIMEOUT_EN
    vt = '{24'h000777, 5'b11110, 1, 3, 1'b0, 32'h1E000777,
           {5'b0, 5'b10000, 5'b01000, 5'b00100, 5'b00010}, 4, 40};
    run_fill(vt, 5'b00010, 5'b00010, "timeout");
    run_fill(vecs[3], 5'b0, 5'b0, "after_timeout");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
